// File: rtl/pll_lock_sequencer.sv
// Per-channel PLL supervisor: pulses RESETB, waits for and qualifies LOCK, then
// releases the channel's domain reset; bounded retries on timeout, then latches a fault.
module pll_lock_sequencer #(
  parameter int NUM_PLLS            = 2,
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_PLLS-1:0]   pll_lock,
  input  logic [NUM_PLLS-1:0]   relock_req,
  input  logic [NUM_PLLS-1:0]   clear_fault,
  output logic [NUM_PLLS-1:0]   pll_resetb,
  output logic [NUM_PLLS-1:0]   domain_resetn,
  output logic                  all_locked,
  output logic [NUM_PLLS-1:0]   fault,
  output logic [4*NUM_PLLS-1:0] retry_count
);

  localparam int MAX_AB  = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RESET_CYCLES
                                                                  : LOCK_STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [NUM_PLLS-1:0] lock_sync_p0;
  logic [NUM_PLLS-1:0] lock_sync_p1;
  logic [NUM_PLLS-1:0] run_vec;

  // Stage p0/p1: two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_sync_p0 <= '0;
      lock_sync_p1 <= '0;
    end else begin
      lock_sync_p0 <= pll_lock;
      lock_sync_p1 <= lock_sync_p0;
    end
  end

  for (genvar ch = 0; ch < NUM_PLLS; ch++) begin : g_ch
    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [3:0]      retry, retry_nxt;
    logic            lock_s;
    logic            resetb_q, domain_q, fault_q;

    assign lock_s = lock_sync_p1[ch];

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry;
      case (state)
        ST_RST: begin
          if (cnt == RST_LAST) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_nxt = '0;
            if (retry == RETRY_LIMIT) begin
              state_nxt = ST_FAULT;
            end else begin
              state_nxt = ST_RST;
              retry_nxt = sat_inc4(retry);
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nxt = ST_RST;
            cnt_nxt   = '0;
          end
        end
        ST_FAULT: begin
          if (clear_fault[ch]) begin
            state_nxt = ST_RST;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_RST;
          cnt_nxt   = '0;
        end
      endcase
      // A relock request outranks lock loss and timeout, but never releases a fault
      if (relock_req[ch] && (state != ST_FAULT)) begin
        state_nxt = ST_RST;
        cnt_nxt   = '0;
        retry_nxt = retry;
      end
    end

    // Outputs are decoded from the next state so they change on the transition edge
    always_ff @(posedge clk) begin
      if (!resetn) begin
        state    <= ST_RST;
        cnt      <= '0;
        retry    <= '0;
        resetb_q <= 1'b0;
        domain_q <= 1'b0;
        fault_q  <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        retry    <= retry_nxt;
        resetb_q <= (state_nxt != ST_RST) && (state_nxt != ST_FAULT);
        domain_q <= (state_nxt == ST_RUN);
        fault_q  <= (state_nxt == ST_FAULT);
      end
    end

    assign pll_resetb[ch]         = resetb_q;
    assign domain_resetn[ch]      = domain_q;
    assign fault[ch]              = fault_q;
    assign retry_count[4*ch +: 4] = retry;
    assign run_vec[ch]            = (state == ST_RUN);
  end

  // Built from the current state, so it trails domain_resetn by one cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      all_locked <= 1'b0;
    end else begin
      all_locked <= &run_vec;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: expectations are queued with a due cycle
// when stimulus is applied and compared when that cycle's outputs are sampled.
module tb_pll_lock_sequencer;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   pll_lock, relock_req, clear_fault;
  logic [N-1:0]   pll_resetb, domain_resetn, fault;
  logic           all_locked;
  logic [4*N-1:0] retry_count;

  pll_lock_sequencer #(
    .NUM_PLLS(N), .PLL_RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .pll_lock(pll_lock), .relock_req(relock_req),
    .clear_fault(clear_fault), .pll_resetb(pll_resetb), .domain_resetn(domain_resetn),
    .all_locked(all_locked), .fault(fault), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  localparam int S_RB = 0, S_DR = 1, S_AL = 2, S_FL = 3, S_RC = 4;

  typedef struct {
    int         due;
    string      tag;
    int         sig;
    int         idx;
    logic [3:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  cyc;
  int  checks = 0;
  int  errors = 0;

  function automatic logic [3:0] obs(int sig, int idx);
    case (sig)
      S_RB:    return {3'b000, pll_resetb[idx]};
      S_DR:    return {3'b000, domain_resetn[idx]};
      S_AL:    return {3'b000, all_locked};
      S_FL:    return {3'b000, fault[idx]};
      default: return retry_count[4*idx +: 4];
    endcase
  endfunction

  task automatic check(string tag, logic [3:0] o, logic [3:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  task automatic expect_at(int due, string tag, int sig, int idx, logic [3:0] e);
    sb_t s;
    s.due = due; s.tag = tag; s.sig = sig; s.idx = idx; s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic step();
    sb_t keep[$];
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].due == cyc) check(sbq[i].tag, obs(sbq[i].sig, sbq[i].idx), sbq[i].exp);
      else keep.push_back(sbq[i]);
    end
    sbq = keep;
  endtask

  task automatic run_to(int t);
    while (cyc < t) step();
  endtask

  initial begin
    resetn = 1'b0; pll_lock = '0; relock_req = '0; clear_fault = '0;
    cyc = -100;
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      check("rst_resetb", obs(S_RB, i), 4'd0);
      check("rst_domain", obs(S_DR, i), 4'd0);
      check("rst_fault",  obs(S_FL, i), 4'd0);
      check("rst_retry",  obs(S_RC, i), 4'd0);
    end
    check("rst_all_locked", obs(S_AL, 0), 4'd0);

    // Release: the next edge is cycle index 0
    resetn = 1'b1;
    cyc = -1;
    for (int t = 0; t < 3; t++) expect_at(t, "a_resetb0_low", S_RB, 0, 4'd0);
    expect_at(3,   "a_resetb0_high",  S_RB, 0, 4'd1);
    expect_at(3,   "a_resetb1_high",  S_RB, 1, 4'd1);
    expect_at(19,  "a_domain0_pre",   S_DR, 0, 4'd0);
    expect_at(20,  "a_domain0_rise",  S_DR, 0, 4'd1);
    expect_at(21,  "a_all_locked_lo", S_AL, 0, 4'd0);
    expect_at(34,  "a_retry1_0",      S_RC, 1, 4'd0);
    expect_at(35,  "a_retry1_1",      S_RC, 1, 4'd1);
    expect_at(35,  "a_resetb1_retry", S_RB, 1, 4'd0);
    expect_at(39,  "a_resetb1_rel",   S_RB, 1, 4'd1);
    expect_at(70,  "a_retry1_1b",     S_RC, 1, 4'd1);
    expect_at(71,  "a_retry1_2",      S_RC, 1, 4'd2);
    expect_at(106, "a_fault1_pre",    S_FL, 1, 4'd0);
    expect_at(107, "a_fault1_rise",   S_FL, 1, 4'd1);
    expect_at(107, "a_resetb1_fault", S_RB, 1, 4'd0);
    expect_at(107, "a_domain0_kept",  S_DR, 0, 4'd1);
    expect_at(107, "a_fault0_clear",  S_FL, 0, 4'd0);
    expect_at(107, "a_retry0_zero",   S_RC, 0, 4'd0);
    check("a_resetb0_cycle0", obs(S_RB, 0), 4'd0);
    run_to(9);
    pll_lock[0] = 1'b1;
    run_to(110);

    // Relock ignored in FAULT; clear_fault ignored outside FAULT
    relock_req[1] = 1'b1; clear_fault[0] = 1'b1;
    expect_at(111, "b_fault1_kept",   S_FL, 1, 4'd1);
    expect_at(113, "b_fault1_kept2",  S_FL, 1, 4'd1);
    expect_at(111, "b_domain0_kept",  S_DR, 0, 4'd1);
    expect_at(112, "b_domain0_kept2", S_DR, 0, 4'd1);
    step();
    relock_req = '0; clear_fault = '0;
    run_to(113);

    // clear_fault with relock_req in FAULT: restart with lock already present
    check("b_retry1_pre", obs(S_RC, 1), 4'd2);
    clear_fault[1] = 1'b1; relock_req[1] = 1'b1; pll_lock[1] = 1'b1;
    expect_at(114, "b_fault1_clr",    S_FL, 1, 4'd0);
    expect_at(114, "b_retry1_clr",    S_RC, 1, 4'd0);
    for (int t = 114; t <= 117; t++) expect_at(t, "b_resetb1_low", S_RB, 1, 4'd0);
    expect_at(118, "b_resetb1_high",  S_RB, 1, 4'd1);
    expect_at(126, "b_domain1_pre",   S_DR, 1, 4'd0);
    expect_at(127, "b_domain1_rise",  S_DR, 1, 4'd1);
    expect_at(127, "b_all_lock_lag",  S_AL, 0, 4'd0);
    expect_at(128, "b_all_locked",    S_AL, 0, 4'd1);
    step();
    clear_fault = '0; relock_req = '0;
    run_to(130);

    // Lock loss in RUN and automatic re-sequence
    pll_lock[0] = 1'b0;
    expect_at(132, "c_domain0_hold",  S_DR, 0, 4'd1);
    expect_at(133, "c_domain0_fall",  S_DR, 0, 4'd0);
    expect_at(133, "c_all_lock_hold", S_AL, 0, 4'd1);
    expect_at(134, "c_all_lock_fall", S_AL, 0, 4'd0);
    expect_at(132, "c_resetb0_hold",  S_RB, 0, 4'd1);
    for (int t = 133; t <= 136; t++) expect_at(t, "c_resetb0_low", S_RB, 0, 4'd0);
    expect_at(137, "c_resetb0_high",  S_RB, 0, 4'd1);
    expect_at(140, "c_domain1_indep", S_DR, 1, 4'd1);
    expect_at(145, "c_domain0_pre",   S_DR, 0, 4'd0);
    expect_at(146, "c_domain0_rise",  S_DR, 0, 4'd1);
    expect_at(147, "c_all_lock_back", S_AL, 0, 4'd1);
    run_to(135);
    pll_lock[0] = 1'b1;
    run_to(150);

    // Relock into a STABLE window that is interrupted by a 3-cycle lock drop
    relock_req[0] = 1'b1;
    expect_at(151, "d_domain0_fall",  S_DR, 0, 4'd0);
    expect_at(151, "d_resetb0_low",   S_RB, 0, 4'd0);
    expect_at(152, "d_all_lock_fall", S_AL, 0, 4'd0);
    expect_at(155, "d_resetb0_high",  S_RB, 0, 4'd1);
    expect_at(161, "d_resetb0_wait",  S_RB, 0, 4'd1);
    expect_at(162, "d_resetb0_wait2", S_RB, 0, 4'd1);
    expect_at(164, "d_no_early_run",  S_DR, 0, 4'd0);
    expect_at(171, "d_domain0_pre",   S_DR, 0, 4'd0);
    expect_at(172, "d_domain0_rise",  S_DR, 0, 4'd1);
    expect_at(173, "d_all_locked",    S_AL, 0, 4'd1);
    expect_at(172, "d_retry0_kept",   S_RC, 0, 4'd0);
    step();
    relock_req = '0;
    run_to(158);
    pll_lock[0] = 1'b0;
    run_to(161);
    pll_lock[0] = 1'b1;
    run_to(180);

    // Relock coinciding with lock loss: a single reset pulse
    pll_lock[0] = 1'b0;
    expect_at(182, "e_resetb0_hold",  S_RB, 0, 4'd1);
    for (int t = 183; t <= 186; t++) expect_at(t, "e_resetb0_low", S_RB, 0, 4'd0);
    expect_at(187, "e_resetb0_high",  S_RB, 0, 4'd1);
    expect_at(188, "e_resetb0_high2", S_RB, 0, 4'd1);
    expect_at(183, "e_domain0_fall",  S_DR, 0, 4'd0);
    run_to(182);
    relock_req[0] = 1'b1;
    step();
    relock_req = '0;
    run_to(188);
    pll_lock[0] = 1'b1;
    run_to(193);

    // resetn low mid-STABLE on channel 0 while channel 1 is running
    check("f_domain1_pre", obs(S_DR, 1), 4'd1);
    check("f_resetb1_pre", obs(S_RB, 1), 4'd1);
    resetn = 1'b0;
    step();
    for (int i = 0; i < N; i++) begin
      check("f_resetb", obs(S_RB, i), 4'd0);
      check("f_domain", obs(S_DR, i), 4'd0);
      check("f_fault",  obs(S_FL, i), 4'd0);
      check("f_retry",  obs(S_RC, i), 4'd0);
    end
    check("f_all_locked", obs(S_AL, 0), 4'd0);
    resetn = 1'b1;
    expect_at(197, "f_resetb0_low",   S_RB, 0, 4'd0);
    expect_at(198, "f_resetb0_high",  S_RB, 0, 4'd1);
    expect_at(206, "f_domain1_pre",   S_DR, 1, 4'd0);
    expect_at(207, "f_domain1_rise",  S_DR, 1, 4'd1);
    expect_at(207, "f_domain0_rise",  S_DR, 0, 4'd1);
    expect_at(208, "f_all_locked",    S_AL, 0, 4'd1);
    run_to(210);

    for (int i = 0; i < sbq.size(); i++) begin
      check({"unchecked_", sbq[i].tag}, 4'd1, 4'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
